// File: rtl/mini_core_pkg.sv
// Shared types and constants for the mini core data-memory path.
// The arbiter, its bus interface and the bench all import this package.
package mini_core_pkg;

  localparam int DMEM_BE_W  = 4;
  localparam int STARVE_W   = 4;
  localparam int DMEM_DW    = 32;

  // Records who owns the SRAM read data that arrives one cycle after a grant.
  typedef enum logic [1:0] {
    OWN_NONE    = 2'd0,
    OWN_CORE_RD = 2'd1,
    OWN_EXT     = 2'd2
  } t_dmem_owner;

  function automatic logic [STARVE_W-1:0] sat_inc(input logic [STARVE_W-1:0] v);
    sat_inc = (v == {STARVE_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/mini_core_dmem_arb_if.sv
// Bus bundle for the data-memory arbiter: core port, external port, SRAM port
// and arbiter debug state. "slave" is the arbiter view, "master" the environment view.
interface mini_core_dmem_arb_if #(
  parameter int MEM_AW = 12
);
  import mini_core_pkg::*;

  // Core Q103H request side
  logic                  CoreRdEnQ103H;
  logic                  CoreWrEnQ103H;
  logic [31:0]           CoreAddrQ103H;
  logic [31:0]           CoreWrDataQ103H;
  logic [DMEM_BE_W-1:0]  CoreByteEnQ103H;
  logic                  DMemReady;
  logic [31:0]           CoreRdDataQ104H;

  // External requester: ExtReq/ExtWrEn/ExtAddr/ExtWrData/ExtByteEn are held stable
  // until ExtGnt is seen high; ExtGnt high in a cycle means the access was taken in
  // that cycle, and ExtRspValid pulses exactly one cycle later for reads and writes.
  logic                  ExtReq;
  logic                  ExtWrEn;
  logic [31:0]           ExtAddr;
  logic [31:0]           ExtWrData;
  logic [DMEM_BE_W-1:0]  ExtByteEn;
  logic                  ExtGnt;
  logic                  ExtRspValid;
  logic [31:0]           ExtRdData;

  // Single-port SRAM
  logic                  MemEn;
  logic                  MemWrEn;
  logic [MEM_AW-1:0]     MemAddr;
  logic [31:0]           MemWrData;
  logic [DMEM_BE_W-1:0]  MemByteEn;
  logic [31:0]           MemRdData;

  // Debug view of internal state
  logic [STARVE_W-1:0]   StarveCntDbg;
  t_dmem_owner           RspOwnDbg;

  modport slave (
    input  CoreRdEnQ103H, CoreWrEnQ103H, CoreAddrQ103H, CoreWrDataQ103H, CoreByteEnQ103H,
    output DMemReady, CoreRdDataQ104H,
    input  ExtReq, ExtWrEn, ExtAddr, ExtWrData, ExtByteEn,
    output ExtGnt, ExtRspValid, ExtRdData,
    output MemEn, MemWrEn, MemAddr, MemWrData, MemByteEn,
    input  MemRdData,
    output StarveCntDbg, RspOwnDbg
  );

  modport master (
    output CoreRdEnQ103H, CoreWrEnQ103H, CoreAddrQ103H, CoreWrDataQ103H, CoreByteEnQ103H,
    input  DMemReady, CoreRdDataQ104H,
    output ExtReq, ExtWrEn, ExtAddr, ExtWrData, ExtByteEn,
    input  ExtGnt, ExtRspValid, ExtRdData,
    input  MemEn, MemWrEn, MemAddr, MemWrData, MemByteEn,
    output MemRdData,
    input  StarveCntDbg, RspOwnDbg
  );

endinterface

// File: rtl/mini_core_dmem_arb.sv
// Arbiter/sequencer for the single-port data SRAM shared by the core memory stage
// and an external port; the core has priority, a starvation counter bounds ext waits.
module mini_core_dmem_arb
  import mini_core_pkg::*;
#(
  parameter int MEM_AW         = 12,
  parameter int MAX_CORE_BURST = 4
) (
  input  logic                  Clock,
  input  logic                  RstN,
  mini_core_dmem_arb_if.slave   bus
);

  logic                 core_req;
  logic                 ext_win;
  logic                 core_gnt;
  logic                 ext_gnt;

  logic [STARVE_W-1:0]  starve_cnt_q, starve_cnt_d;
  t_dmem_owner          rsp_own_q,    rsp_own_d;
  logic                 ext_wr_last_q, ext_wr_last_d;
  logic [31:0]          core_rd_data_q, core_rd_data_d;
  logic [31:0]          ext_rd_data_q,  ext_rd_data_d;

  // Address bits above the SRAM word index are deliberately dropped (aliasing).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.CoreAddrQ103H[31:MEM_AW+2], bus.CoreAddrQ103H[1:0],
                              bus.ExtAddr[31:MEM_AW+2],       bus.ExtAddr[1:0]};

  always_comb begin
    core_req = bus.CoreRdEnQ103H | bus.CoreWrEnQ103H;
    ext_win  = bus.ExtReq &
               (!core_req | (starve_cnt_q >= STARVE_W'(MAX_CORE_BURST)));
    ext_gnt  = ext_win;
    core_gnt = core_req & !ext_win;

    bus.DMemReady = !core_req | core_gnt;
    bus.ExtGnt    = ext_gnt;
  end

  // SRAM mux: idle cycles drive all-zero so the SRAM pins are quiet.
  always_comb begin
    bus.MemEn     = core_gnt | ext_gnt;
    bus.MemWrEn   = 1'b0;
    bus.MemAddr   = '0;
    bus.MemWrData = '0;
    bus.MemByteEn = '0;
    if (core_gnt) begin
      bus.MemWrEn   = bus.CoreWrEnQ103H;
      bus.MemAddr   = bus.CoreAddrQ103H[MEM_AW+1:2];
      bus.MemWrData = bus.CoreWrDataQ103H;
      bus.MemByteEn = bus.CoreByteEnQ103H;
    end else if (ext_gnt) begin
      bus.MemWrEn   = bus.ExtWrEn;
      bus.MemAddr   = bus.ExtAddr[MEM_AW+1:2];
      bus.MemWrData = bus.ExtWrData;
      bus.MemByteEn = bus.ExtByteEn;
    end
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (ext_gnt || !bus.ExtReq) begin
      starve_cnt_d = '0;
    end else if (core_gnt) begin
      starve_cnt_d = sat_inc(starve_cnt_q);
    end

    rsp_own_d = OWN_NONE;
    if (core_gnt && bus.CoreRdEnQ103H) begin
      rsp_own_d = OWN_CORE_RD;
    end else if (ext_gnt) begin
      rsp_own_d = OWN_EXT;
    end

    ext_wr_last_d = ext_wr_last_q;
    if (ext_gnt) begin
      ext_wr_last_d = bus.ExtWrEn;
    end
  end

  // The SRAM output register is the first Q104H stage: the response cycle shows
  // MemRdData directly, and the _q copies hold it through later cycles and freezes.
  always_comb begin
    core_rd_data_d = core_rd_data_q;
    if (rsp_own_q == OWN_CORE_RD) begin
      core_rd_data_d = bus.MemRdData;
    end

    ext_rd_data_d = ext_rd_data_q;
    if (rsp_own_q == OWN_EXT && !ext_wr_last_q) begin
      ext_rd_data_d = bus.MemRdData;
    end

    bus.CoreRdDataQ104H = core_rd_data_d;
    bus.ExtRdData       = ext_rd_data_d;
    bus.ExtRspValid     = (rsp_own_q == OWN_EXT);
    bus.StarveCntDbg    = starve_cnt_q;
    bus.RspOwnDbg       = rsp_own_q;
  end

  always_ff @(posedge Clock or negedge RstN) begin
    if (!RstN) begin
      starve_cnt_q   <= '0;
      rsp_own_q      <= OWN_NONE;
      ext_wr_last_q  <= 1'b0;
      core_rd_data_q <= '0;
      ext_rd_data_q  <= '0;
    end else begin
      starve_cnt_q   <= starve_cnt_d;
      rsp_own_q      <= rsp_own_d;
      ext_wr_last_q  <= ext_wr_last_d;
      core_rd_data_q <= core_rd_data_d;
      ext_rd_data_q  <= ext_rd_data_d;
    end
  end

endmodule

// File: doc/mini_core_dmem_arb.md
Name: mini_core_dmem_arb

Overview:
Arbiter and sequencer for the single-port data memory, shared between two requesters: the core Q103H memory stage and an external requester (debug/loader/fabric port).
- The core normally has priority. A bounded-starvation counter guarantees the external port a slot.
- When the core's request is not granted, the block drops DMemReady, which freezes the whole core pipe.
- It holds the returned read data stable in Q104H across freezes.

Parameters:
MEM_AW, 12, word-address width of the data SRAM; the SRAM holds 2^MEM_AW 32-bit words.
MAX_CORE_BURST, 4, maximum consecutive core grants while ExtReq is pending; range 1..15.

Ports:
Clock  in  1  core clock; all state updates on its rising edge.
RstN  in  1  asynchronous, active-low reset.
CoreRdEnQ103H  in  1  core load request.
CoreWrEnQ103H  in  1  core store request; never asserted together with CoreRdEnQ103H.
CoreAddrQ103H  in  32  core byte address; bits [MEM_AW+1:2] are used.
CoreWrDataQ103H  in  32  core store data.
CoreByteEnQ103H  in  4  core byte enables.
DMemReady  out  1  core may advance; low means the core pipe freezes.
CoreRdDataQ104H  out  32  registered load data for the core WB stage.
ExtReq  in  1  external request; held stable until ExtGnt.
ExtWrEn  in  1  1 = write, 0 = read.
ExtAddr  in  32  external byte address.
ExtWrData  in  32  external write data.
ExtByteEn  in  4  external byte enables.
ExtGnt  out  1  external request accepted this cycle (combinational).
ExtRspValid  out  1  one-cycle pulse, exactly 1 cycle after ExtGnt, for reads and writes.
ExtRdData  out  32  read data; valid while ExtRspValid=1, held afterwards.
MemEn  out  1  SRAM access enable.
MemWrEn  out  1  SRAM write enable.
MemAddr  out  MEM_AW  SRAM word address.
MemWrData  out  32  SRAM write data.
MemByteEn  out  4  SRAM byte-write mask.
MemRdData  in  32  SRAM read data; valid 1 cycle after MemEn with MemWrEn=0.

Behaviour:
- Definitions: CoreReq = CoreRdEnQ103H | CoreWrEnQ103H. StarveCnt is a 4-bit register.
- Grant, combinational each cycle:
  - ExtWin = ExtReq & (!CoreReq | StarveCnt >= MAX_CORE_BURST).
  - ExtGnt = ExtWin. CoreGnt = CoreReq & !ExtWin.
  - At most one grant per cycle.
- DMemReady = !CoreReq | CoreGnt. The core holds its Q103H inputs while DMemReady=0.
- SRAM mux:
  - CoreGnt drives Mem* from the Core* inputs.
  - ExtGnt drives Mem* from the Ext* inputs.
  - Otherwise MemEn=0 and all other Mem* outputs are 0.
  - MemEn = CoreGnt | ExtGnt.
- StarveCnt:
  - Cleared to 0 on ExtGnt, or when ExtReq=0.
  - Incremented on CoreGnt while ExtReq=1, saturating at 15.
  - Result: the external port waits at most MAX_CORE_BURST cycles.
- Response owner register RspOwn (t_dmem_owner: OWN_NONE, OWN_CORE_RD, OWN_EXT), loaded every cycle:
  - OWN_CORE_RD if CoreGnt & CoreRdEnQ103H.
  - OWN_EXT if ExtGnt.
  - OWN_NONE otherwise.
- Response path, acting on the previous cycle's owner:
  - RspOwn==OWN_CORE_RD: CoreRdDataQ104H <= MemRdData.
  - RspOwn==OWN_EXT: ExtRspValid=1, and ExtRdData <= MemRdData if that access was a read. A registered ExtWrLast bit records this.
- Holding rules:
  - CoreRdDataQ104H holds its value in all other cycles, so a freeze (DMemReady=0 for an ext slot) never corrupts Q104H data.
  - ExtRdData likewise holds.
- Latency: core load granted at cycle N → CoreRdDataQ104H valid from N+1 and held until the next core load response. External access granted at N → ExtRspValid at N+1.
- Ordering: accesses commit in grant order. A write at N followed by a read of the same word at N+1 from the other port returns the new data.
- Boundaries:
  - ExtReq=1 with CoreReq=0: immediate grant.
  - MAX_CORE_BURST reached with both requesting: the ext slot forces exactly one freeze cycle on the core.
  - Writes with ByteEn=4'b0000 still consume a slot and still produce ExtRspValid.
  - Address bits above MEM_AW+1 are ignored (aliasing).
- Reset (RstN=0, asynchronous):
  - StarveCnt=0, RspOwn=OWN_NONE, ExtWrLast=0, CoreRdDataQ104H=0, ExtRdData=0, ExtRspValid=0.
  - Any response in flight is discarded.
  - Combinational outputs follow their inputs but, with state cleared, grant only per the rules above.

Decomposition:
- In mini_core_pkg: typedef enum t_dmem_owner {OWN_NONE, OWN_CORE_RD, OWN_EXT}; constant DMEM_BE_W = 4.
- No sub-module needed. The arbiter, counter and response registers form one block, about 150 lines.

Test Plan:
1. Core LW at addr 0x10 only, SRAM word 4 = 0xDEADBEEF → DMemReady=1, MemEn=1, MemAddr=4; CoreRdDataQ104H=0xDEADBEEF next cycle and held.
2. ExtReq write of 0x12345678 to 0x20 with core idle → ExtGnt same cycle, MemWrEn=1, MemAddr=8; ExtRspValid pulses 1 cycle later.
3. Core requesting every cycle, ExtReq held, MAX_CORE_BURST=4 → 4 core grants, then ExtGnt with DMemReady=0 for exactly 1 cycle; StarveCnt returns to 0.
4. Core LW granted at N, ext slot at N+1 → CoreRdDataQ104H keeps the core's data through N+2; ExtRdData gets the ext word.
5. Ext write 0xAA to word 3 at N, core LW of word 3 at N+1 → CoreRdDataQ104H=0x000000AA (with ByteEn=0001 over an old value of 0).
6. RstN asserted the cycle after an ext read grant → ExtRspValid never pulses; all registers read 0; after release the first core load behaves as in scenario 1.
